// File: rtl/hwpe_stream_addressgen_nd.sv
// N-dimensional address generator: NB_DIMS nested loops with signed strides,
// one address per cycle on a valid/ready stream, start/done control handshake.
module hwpe_stream_addressgen_nd #(
   parameter int NB_DIMS      = 3,
   parameter int ADDR_WIDTH   = 32,
   parameter int LEN_WIDTH    = 16,
   parameter int STRIDE_WIDTH = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [ADDR_WIDTH-1:0]           base_addr_i,
   input  logic [NB_DIMS*LEN_WIDTH-1:0]    len_i,
   input  logic [NB_DIMS*STRIDE_WIDTH-1:0] stride_i,
   output logic                            ready_start_o,
   output logic                            done_o,
   output logic                            in_progress_o,
   output logic                            addr_valid_o,
   input  logic                            addr_ready_i,
   output logic [ADDR_WIDTH-1:0]           addr_o,
   output logic [NB_DIMS-1:0]              dim_last_o,
   output logic                            last_o
);

   typedef enum logic [1:0] {IDLE, WORKING, DONE} state_t;

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  idx_q    [NB_DIMS];
   logic [LEN_WIDTH-1:0]  idx_d    [NB_DIMS];
   logic [LEN_WIDTH-1:0]  lastidx_q[NB_DIMS];
   logic [ADDR_WIDTH-1:0] ptr_q    [NB_DIMS];
   logic [ADDR_WIDTH-1:0] ptr_d    [NB_DIMS];
   logic [ADDR_WIDTH-1:0] stride_q [NB_DIMS];
   logic [ADDR_WIDTH-1:0] carry_ptr;
   logic [NB_DIMS-1:0]    at_last;
   logic [NB_DIMS:0]      carry;
   logic                  handshake;

   assign handshake     = (state_q == WORKING) && addr_ready_i;
   assign ready_start_o = (state_q == IDLE);
   assign in_progress_o = (state_q == WORKING);
   assign done_o        = (state_q == DONE);
   assign addr_valid_o  = (state_q == WORKING);
   assign addr_o        = ptr_q[0];
   assign last_o        = dim_last_o[NB_DIMS-1];
   assign carry[0]      = handshake;

   // carry[d+1]: dims 0..d all wrap on this handshake; carry[NB_DIMS] marks the final beat
   for (genvar gi = 0; gi < NB_DIMS; gi++) begin : g_dim
      assign at_last[gi]    = (idx_q[gi] == lastidx_q[gi]);
      assign carry[gi+1]    = handshake && (&at_last[gi:0]);
      assign dim_last_o[gi] = addr_valid_o && (&at_last[gi:0]);
   end

   // The lowest non-wrapping dim steps; every dim below it restarts from that new pointer.
   always_comb begin
      carry_ptr = '0;
      for (int d = NB_DIMS - 1; d >= 0; d--) begin
         idx_d[d] = idx_q[d];
         ptr_d[d] = ptr_q[d];
         if (carry[d] && !at_last[d]) begin
            carry_ptr = ptr_q[d] + stride_q[d];
            idx_d[d]  = idx_q[d] + 1'b1;
            ptr_d[d]  = carry_ptr;
         end else if (carry[d+1] && !carry[NB_DIMS]) begin
            idx_d[d] = '0;
            ptr_d[d] = carry_ptr;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = WORKING;
         WORKING: if (carry[NB_DIMS]) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int d = 0; d < NB_DIMS; d++) begin
            idx_q[d]     <= '0;
            lastidx_q[d] <= '0;
            ptr_q[d]     <= '0;
            stride_q[d]  <= '0;
         end
      end else if (state_q == IDLE && start_i) begin
         // a zero length runs as a single iteration
         for (int d = 0; d < NB_DIMS; d++) begin
            idx_q[d]     <= '0;
            ptr_q[d]     <= base_addr_i;
            lastidx_q[d] <= (len_i[d*LEN_WIDTH +: LEN_WIDTH] == '0) ? '0
                            : len_i[d*LEN_WIDTH +: LEN_WIDTH] - 1'b1;
            stride_q[d]  <= ADDR_WIDTH'($signed(stride_i[d*STRIDE_WIDTH +: STRIDE_WIDTH]));
         end
      end else if (handshake) begin
         for (int d = 0; d < NB_DIMS; d++) begin
            idx_q[d] <= idx_d[d];
            ptr_q[d] <= ptr_d[d];
         end
      end
   end

endmodule

// File: tb/tb_hwpe_stream_addressgen_nd.sv
// Bench for hwpe_stream_addressgen_nd: directed and random runs checked against
// a mixed-radix reference model of the nested-loop address sequence.
module tb_hwpe_stream_addressgen_nd;

   localparam int ND = 3;
   localparam int AW = 32;
   localparam int LW = 16;
   localparam int SW = 16;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [AW-1:0]    base_addr_i;
   logic [ND*LW-1:0] len_i;
   logic [ND*SW-1:0] stride_i;
   logic             ready_start_o;
   logic             done_o;
   logic             in_progress_o;
   logic             addr_valid_o;
   logic             addr_ready_i;
   logic [AW-1:0]    addr_o;
   logic [ND-1:0]    dim_last_o;
   logic             last_o;

   int total = 0;
   int bad   = 0;

   logic [AW-1:0] exp_a[$];
   logic [ND-1:0] exp_d[$];

   always #5 clk_i = ~clk_i;

   hwpe_stream_addressgen_nd #(
      .NB_DIMS(ND), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .len_i(len_i), .stride_i(stride_i), .ready_start_o(ready_start_o),
      .done_o(done_o), .in_progress_o(in_progress_o), .addr_valid_o(addr_valid_o),
      .addr_ready_i(addr_ready_i), .addr_o(addr_o), .dim_last_o(dim_last_o),
      .last_o(last_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat n decomposes into per-dimension indices (dim 0 fastest); address is base + sum stride*idx.
   task automatic build(input logic [AW-1:0] base, input logic [ND*LW-1:0] len,
                        input logic [ND*SW-1:0] str);
      int L[ND];
      int n_tot = 1;
      exp_a.delete();
      exp_d.delete();
      for (int d = 0; d < ND; d++) begin
         L[d] = int'(len[d*LW +: LW]);
         if (L[d] == 0) L[d] = 1;
         n_tot *= L[d];
      end
      for (int n = 0; n < n_tot; n++) begin
         int            rem = n;
         logic [AW-1:0] a   = base;
         logic [ND-1:0] dl  = '0;
         bit            all = 1'b1;
         for (int d = 0; d < ND; d++) begin
            int i = rem % L[d];
            rem = rem / L[d];
            a   = a + 32'(longint'($signed(str[d*SW +: SW])) * longint'(i));
            all = all && (i == L[d] - 1);
            dl[d] = all;
         end
         exp_a.push_back(a);
         exp_d.push_back(dl);
      end
   endtask

   task automatic run(input string nm, input logic [AW-1:0] base, input logic [ND*LW-1:0] len,
                      input logic [ND*SW-1:0] str, input int rdy_pct, input bit poke);
      int cnt = 0;
      int cyc = 0;
      int n;
      build(base, len, str);
      n = exp_a.size();
      chk({nm, "/ready_start_before"}, ready_start_o, 1);
      base_addr_i  = base;
      len_i        = len;
      stride_i     = str;
      start_i      = 1'b1;
      addr_ready_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0;
      while (cnt < n && cyc < 4000) begin
         chk({nm, "/valid"}, addr_valid_o, 1);
         chk({nm, "/addr"}, addr_o, exp_a[cnt]);
         chk({nm, "/dim_last"}, dim_last_o, exp_d[cnt]);
         chk({nm, "/last"}, last_o, exp_d[cnt][ND-1]);
         chk({nm, "/ready_start_busy"}, ready_start_o, 0);
         chk({nm, "/in_progress"}, in_progress_o, 1);
         chk({nm, "/done_early"}, done_o, 0);
         if (poke) begin
            start_i     = 1'b1;
            base_addr_i = $urandom;
            len_i       = {$urandom, $urandom};
            stride_i    = {$urandom, $urandom};
         end
         addr_ready_i = ($urandom_range(99) < rdy_pct);
         if (addr_ready_i) cnt++;
         cyc++;
         @(negedge clk_i);
      end
      chk({nm, "/beats_in_budget"}, cnt, n);
      start_i      = 1'b0;
      addr_ready_i = 1'b0;
      chk({nm, "/valid_after"}, addr_valid_o, 0);
      chk({nm, "/done"}, done_o, 1);
      chk({nm, "/ready_start_in_done"}, ready_start_o, 0);
      @(negedge clk_i);
      chk({nm, "/ready_start_after"}, ready_start_o, 1);
      chk({nm, "/done_one_cycle"}, done_o, 0);
      chk({nm, "/valid_idle"}, addr_valid_o, 0);
   endtask

   localparam logic [ND*LW-1:0] LEN3 = {16'd2, 16'd3, 16'd2};
   localparam logic [ND*SW-1:0] STR3 = {16'h1000, 16'h0100, 16'h0004};

   initial begin
      rst_i        = 1'b1;
      start_i      = 1'b0;
      addr_ready_i = 1'b0;
      base_addr_i  = '0;
      len_i        = '0;
      stride_i     = '0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      chk("reset/ready_start", ready_start_o, 1);
      chk("reset/done", done_o, 0);
      chk("reset/in_progress", in_progress_o, 0);
      chk("reset/valid", addr_valid_o, 0);
      chk("reset/addr", addr_o, 0);
      chk("reset/dim_last", dim_last_o, 0);
      chk("reset/last", last_o, 0);
      @(negedge clk_i);

      run("1d", 32'h1000, {16'd0, 16'd0, 16'd4}, {16'd0, 16'd0, 16'd4}, 100, 1'b0);
      run("3d", 32'h0, LEN3, STR3, 100, 1'b0);
      run("3d_bp", 32'h0, LEN3, STR3, 50, 1'b0);
      run("neg_stride", 32'h10, {16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'hFFFC}, 100, 1'b0);
      run("wrap", 32'h0, {16'd0, 16'd0, 16'd2}, {16'd0, 16'd0, 16'hFFFC}, 100, 1'b0);
      run("len0", 32'hABCD0, '0, STR3, 100, 1'b0);
      run("poke", 32'h400, LEN3, STR3, 70, 1'b1);
      for (int r = 0; r < 6; r++) begin
         run("rand", $urandom,
             {16'($urandom_range(3)), 16'($urandom_range(3)), 16'($urandom_range(4))},
             {16'($urandom), 16'($urandom), 16'($urandom)}, 60, 1'b0);
      end

      // reset while beat 3 of 12 is pending
      build(32'h0, LEN3, STR3);
      base_addr_i  = 32'h0;
      len_i        = LEN3;
      stride_i     = STR3;
      start_i      = 1'b1;
      @(negedge clk_i);
      start_i      = 1'b0;
      addr_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_mid/beat3_addr", addr_o, exp_a[2]);
      addr_ready_i = 1'b0;
      rst_i        = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_mid/ready_start", ready_start_o, 1);
      chk("rst_mid/valid", addr_valid_o, 0);
      chk("rst_mid/done", done_o, 0);
      chk("rst_mid/in_progress", in_progress_o, 0);
      chk("rst_mid/addr", addr_o, 0);
      @(negedge clk_i);
      chk("rst_mid/no_done", done_o, 0);
      chk("rst_mid/still_idle", ready_start_o, 1);

      // back-to-back runs with start held high; second run uses a fresh base
      base_addr_i  = 32'h2000;
      len_i        = {16'd0, 16'd0, 16'd2};
      stride_i     = {16'd0, 16'd0, 16'd8};
      start_i      = 1'b1;
      addr_ready_i = 1'b1;
      @(negedge clk_i);
      base_addr_i = 32'h3000;
      chk("b2b/run1_beat1", addr_o, 32'h2000);
      chk("b2b/run1_valid", addr_valid_o, 1);
      @(negedge clk_i);
      chk("b2b/run1_beat2", addr_o, 32'h2008);
      chk("b2b/run1_last", last_o, 1);
      @(negedge clk_i);
      chk("b2b/run1_done", done_o, 1);
      chk("b2b/run1_valid_off", addr_valid_o, 0);
      @(negedge clk_i);
      chk("b2b/idle_ready_start", ready_start_o, 1);
      chk("b2b/idle_valid", addr_valid_o, 0);
      @(negedge clk_i);
      chk("b2b/run2_beat1", addr_o, 32'h3000);
      chk("b2b/run2_valid", addr_valid_o, 1);
      @(negedge clk_i);
      chk("b2b/run2_beat2", addr_o, 32'h3008);
      start_i = 1'b0;
      @(negedge clk_i);
      chk("b2b/run2_done", done_o, 1);
      @(negedge clk_i);
      chk("b2b/run2_idle", ready_start_o, 1);
      addr_ready_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
